pio_avalon_master: RTL and testbench

PIO_AVALON_MASTER -- requirements
Module: pio_avalon_master

---
 rtl/pio_avalon_master_if.sv | 45 ++++
 rtl/pio_avalon_master.sv | 138 +++++++++++++
 tb/tb_pio_avalon_master.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_avalon_master_if.sv
// Command/response handshake and Avalon-MM bus bundle for pio_avalon_master.
// The master modport is the view of the bridge itself; the slave modport is
// the view of whatever sits around it (command source, response sink, PIO).
interface pio_avalon_master_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
);
  // Command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_wdata;

  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  // Avalon-MM towards the PIO slave
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_error,
    input  rsp_ready,
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_error,
    output rsp_ready,
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/pio_avalon_master.sv
// pio_avalon_master: turns single read/write commands into zero-wait-state
// Avalon-MM accesses to a PIO slave and returns one response per command.
// Optional feature macro: PIO_AVALON_MASTER_READBACK_EN -- when defined, every
// write is followed by a readback of the same address and the response
// carries the readback value plus a mismatch flag.
module pio_avalon_master #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pio_avalon_master_if.master   bus,
  output logic [15:0]           txn_count
);

`ifdef PIO_AVALON_MASTER_READBACK_EN
  typedef enum logic [2:0] {IDLE, WR, RD, RBK, RSP} state_t;
`else
  typedef enum logic [2:0] {IDLE, WR, RD, RSP} state_t;
`endif

  state_t            state;
  logic              cmd_ready_q;
  logic              cs_q;
  logic              write_n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [15:0]       count_q;
`ifdef PIO_AVALON_MASTER_READBACK_EN
  logic              error_q;
`endif

  // Controller: every output is a register so the bus sees glitch-free strobes.
  // NOTE: state is updated with <= so every branch reads the pre-edge values;
  // blocking assignments here would race against the readers of these regs.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge (synchronous), not in the sensitivity list.
    if (!reset_n) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b1;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      count_q     <= '0;
`ifdef PIO_AVALON_MASTER_READBACK_EN
      error_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready_q is 1 throughout IDLE, so cmd_valid alone is acceptance.
          if (bus.cmd_valid) begin
            addr_q      <= bus.cmd_address;
            wdata_q     <= bus.cmd_wdata;
            cmd_ready_q <= 1'b0;
            cs_q        <= 1'b1;
            write_n_q   <= ~bus.cmd_write;
            state       <= bus.cmd_write ? WR : RD;
          end
        end

        WR: begin
          // The slave samples the write at the end of this cycle.
          write_n_q <= 1'b1;
`ifdef PIO_AVALON_MASTER_READBACK_EN
          // Keep chipselect high: the next cycle reads the same address back.
          state     <= RBK;
`else
          cs_q        <= 1'b0;
          rsp_valid_q <= 1'b1;
          rdata_q     <= '0;
          state       <= RSP;
`endif
        end

        RD: begin
          cs_q        <= 1'b0;
          rsp_valid_q <= 1'b1;
          rdata_q     <= bus.avm_readdata;
`ifdef PIO_AVALON_MASTER_READBACK_EN
          error_q     <= 1'b0;
`endif
          state       <= RSP;
        end

`ifdef PIO_AVALON_MASTER_READBACK_EN
        RBK: begin
          // Compare against the data just written, still held in wdata_q.
          cs_q        <= 1'b0;
          rsp_valid_q <= 1'b1;
          rdata_q     <= bus.avm_readdata;
          error_q     <= (bus.avm_readdata != wdata_q);
          state       <= RSP;
        end
`endif

        RSP: begin
          // Response data stays frozen until the consumer takes it.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            count_q     <= count_q + 16'd1;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          cmd_ready_q <= 1'b1;
          cs_q        <= 1'b0;
          write_n_q   <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rdata_q;
`ifdef PIO_AVALON_MASTER_READBACK_EN
  assign bus.rsp_error      = error_q;
`else
  // Without readback there is nothing to compare, so the flag never rises.
  assign bus.rsp_error      = 1'b0;
`endif
  assign bus.avm_address    = addr_q;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_write_n    = write_n_q;
  assign bus.avm_writedata  = wdata_q;
  assign txn_count          = count_q;

endmodule

// File: tb/tb_pio_avalon_master.sv
// Testbench for pio_avalon_master: a small PIO slave model, a hand-written
// vector table, a reset-abort and counter-wrap sequence, then random traffic
// checked against a word-level reference model of the PIO contents.
module tb_pio_avalon_master;

`ifdef PIO_AVALON_MASTER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [15:0] txn_count;

  pio_avalon_master_if #(.ADDR_W(2), .DATA_W(32)) bus ();

  pio_avalon_master #(.ADDR_W(2), .DATA_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .txn_count (txn_count)
  );

  // PIO slave: four word registers, address 1 is write-only (reads as 0),
  // address 0 comes out of reset holding 0x12345678.
  logic [31:0] pio_mem [4];

  always @(posedge clk) begin
    if (!reset_n) begin
      pio_mem[0] <= 32'h12345678;
      pio_mem[1] <= 32'h0;
      pio_mem[2] <= 32'h0;
      pio_mem[3] <= 32'h0;
    end else if (bus.avm_chipselect && !bus.avm_write_n) begin
      pio_mem[bus.avm_address] <= bus.avm_writedata;
    end
  end

  assign bus.avm_readdata = (bus.avm_chipselect && bus.avm_address != 2'd1)
                          ? pio_mem[bus.avm_address] : 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Reference model: what the PIO should hold, and what a read returns.
  logic [31:0] ref_mem [4];
  logic [15:0] exp_count;

  task automatic ref_reset();
    ref_mem[0] = 32'h12345678;
    ref_mem[1] = 32'h0;
    ref_mem[2] = 32'h0;
    ref_mem[3] = 32'h0;
    exp_count  = 16'h0;
  endtask

  function automatic logic [31:0] ref_read(input logic [1:0] a);
    return (a == 2'd1) ? 32'h0 : ref_mem[a];
  endfunction

  // One complete transaction, starting and ending just after a falling edge.
  // Checks the cycle-exact access and response timing along the way.
  task automatic do_txn(input logic wr, input logic [1:0] a, input logic [31:0] d,
                        input int hold, input logic pulse,
                        input logic [31:0] exp_rdata, input logic exp_error);
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = wr;
    bus.cmd_address = a;
    bus.cmd_wdata   = d;
    check_bit("cmd_ready_idle", bus.cmd_ready, 1'b1);
    @(posedge clk);                    // acceptance, cycle N
    @(negedge clk);                    // access, cycle N+1
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = ~d;
    check_bit("access_chipselect", bus.avm_chipselect, 1'b1);
    check_bit("access_write_n", bus.avm_write_n, ~wr);
    check_word("access_address", 32'(bus.avm_address), 32'(a));
    check_bit("access_cmd_ready", bus.cmd_ready, 1'b0);
    check_bit("access_rsp_valid", bus.rsp_valid, 1'b0);
    if (wr) check_word("access_writedata", bus.avm_writedata, d);
`ifdef PIO_AVALON_MASTER_READBACK_EN
    if (wr) begin
      @(negedge clk);                  // readback, cycle N+2
      check_bit("rbk_chipselect", bus.avm_chipselect, 1'b1);
      check_bit("rbk_write_n", bus.avm_write_n, 1'b1);
      check_word("rbk_address", 32'(bus.avm_address), 32'(a));
      check_bit("rbk_rsp_valid", bus.rsp_valid, 1'b0);
    end
`endif
    @(negedge clk);                    // first response cycle
    check_bit("rsp_valid", bus.rsp_valid, 1'b1);
    check_word("rsp_rdata", bus.rsp_rdata, exp_rdata);
    check_bit("rsp_error", bus.rsp_error, exp_error);
    check_bit("rsp_chipselect", bus.avm_chipselect, 1'b0);
    check_bit("rsp_write_n", bus.avm_write_n, 1'b1);
    for (int k = 0; k < hold; k++) begin
      bus.rsp_ready = 1'b0;
      if (pulse && k == 0) begin
        bus.cmd_valid   = 1'b1;
        bus.cmd_write   = 1'b1;
        bus.cmd_address = 2'd3;
        bus.cmd_wdata   = 32'hBAD0BAD0;
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check_bit("hold_rsp_valid", bus.rsp_valid, 1'b1);
      check_word("hold_rsp_rdata", bus.rsp_rdata, exp_rdata);
      check_bit("hold_rsp_error", bus.rsp_error, exp_error);
      check_bit("hold_cmd_ready", bus.cmd_ready, 1'b0);
      check_bit("hold_chipselect", bus.avm_chipselect, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    exp_count = exp_count + 16'd1;
    @(negedge clk);                    // back in IDLE
    bus.rsp_ready = 1'b0;
    check_bit("done_rsp_valid", bus.rsp_valid, 1'b0);
    check_bit("done_cmd_ready", bus.cmd_ready, 1'b1);
    check_word("txn_count", 32'(txn_count), 32'(exp_count));
  endtask

  // Issue one command with expectations derived from the reference model.
  task automatic model_txn(input logic wr, input logic [1:0] a, input logic [31:0] d, input int hold);
    logic [31:0] er;
    logic        ee;
    if (wr) begin
      ref_mem[a] = d;
      er = RB ? ref_read(a) : 32'h0;
      ee = RB ? (ref_read(a) != d) : 1'b0;
    end else begin
      er = ref_read(a);
      ee = 1'b0;
    end
    do_txn(wr, a, d, hold, 1'b0, er, ee);
  endtask

  typedef struct {
    logic        write;
    logic [1:0]  addr;
    logic [31:0] data;
    int          hold;
    logic        pulse;
    logic [31:0] exp_rdata;
    logic        exp_error;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Hand-written vectors, starting from the PIO reset contents.
    vecs[0] = '{1'b0, 2'd0, 32'h0,        0, 1'b0, 32'h12345678,              1'b0};
    vecs[1] = '{1'b1, 2'd0, 32'hDEADBEEF, 0, 1'b0, RB ? 32'hDEADBEEF : 32'h0, 1'b0};
    vecs[2] = '{1'b0, 2'd0, 32'h0,        0, 1'b0, 32'hDEADBEEF,              1'b0};
    vecs[3] = '{1'b1, 2'd0, 32'hA5A5A5A5, 1, 1'b0, RB ? 32'hA5A5A5A5 : 32'h0, 1'b0};
    vecs[4] = '{1'b1, 2'd1, 32'h00000001, 0, 1'b0, 32'h0,                     RB};
    vecs[5] = '{1'b0, 2'd1, 32'h0,        0, 1'b0, 32'h0,                     1'b0};
    vecs[6] = '{1'b1, 2'd2, 32'hCAFE0002, 0, 1'b0, RB ? 32'hCAFE0002 : 32'h0, 1'b0};
    vecs[7] = '{1'b0, 2'd2, 32'h0,        5, 1'b1, 32'hCAFE0002,              1'b0};
    vecs[8] = '{1'b0, 2'd3, 32'h0,        0, 1'b0, 32'h0,                     1'b0};
    vecs[9] = '{1'b1, 2'd3, 32'hFFFFFFFF, 2, 1'b0, RB ? 32'hFFFFFFFF : 32'h0, 1'b0};

    reset_n         = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_address = 2'd0;
    bus.cmd_wdata   = 32'h0;
    bus.rsp_ready   = 1'b0;
    ref_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("reset_cmd_ready", bus.cmd_ready, 1'b1);
    check_bit("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check_word("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_bit("reset_rsp_error", bus.rsp_error, 1'b0);
    check_bit("reset_chipselect", bus.avm_chipselect, 1'b0);
    check_bit("reset_write_n", bus.avm_write_n, 1'b1);
    check_word("reset_address", 32'(bus.avm_address), 32'h0);
    check_word("reset_writedata", bus.avm_writedata, 32'h0);
    check_word("reset_txn_count", 32'(txn_count), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table vectors; back-to-back, so each starts right after the last completes.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].write) ref_mem[vecs[i].addr] = vecs[i].data;
      do_txn(vecs[i].write, vecs[i].addr, vecs[i].data, vecs[i].hold,
             vecs[i].pulse, vecs[i].exp_rdata, vecs[i].exp_error);
    end
    check_word("pio_addr3_after_table", pio_mem[3], ref_mem[3]);

    // Reset in the middle of a read: no response, everything back to reset values.
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = 1'b0;
    bus.cmd_address = 2'd2;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check_bit("abort_rd_chipselect", bus.avm_chipselect, 1'b1);
    reset_n = 1'b0;
    ref_reset();
    @(negedge clk);
    check_bit("abort_chipselect", bus.avm_chipselect, 1'b0);
    check_bit("abort_rsp_valid", bus.rsp_valid, 1'b0);
    check_bit("abort_cmd_ready", bus.cmd_ready, 1'b1);
    check_word("abort_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_word("abort_txn_count", 32'(txn_count), 32'h0);
    reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_bit("abort_no_response", bus.rsp_valid, 1'b0);
      check_word("abort_count_held", 32'(txn_count), 32'h0);
    end
    bus.rsp_ready = 1'b0;

    // Counter wrap: preload near the top instead of running 65534 transactions.
    force dut.count_q = 16'hFFFE;
    #1 release dut.count_q;
    exp_count = 16'hFFFE;
    @(negedge clk);
    model_txn(1'b0, 2'd0, 32'h0, 0);   // count -> 0xFFFF
    model_txn(1'b0, 2'd0, 32'h0, 0);   // count wraps to 0
    check_word("txn_count_wrapped", 32'(txn_count), 32'h0);

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      model_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                $urandom, $urandom_range(0, 2));
    end
    for (int a = 0; a < 4; a++) begin
      check_word("pio_final_contents", pio_mem[a], ref_mem[a]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
